// File: rtl/ps2_pkg.sv
// Shared constants, event layout and FSM encodings for the PS/2 keyboard event path.
package ps2_pkg;

  localparam logic [7:0] BRK = 8'hF0;
  localparam logic [7:0] EXT = 8'hE0;

  // Keyboard status/response bytes that never form part of a key event.
  localparam logic [7:0] IGN_BAT    = 8'hAA;
  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_BATF   = 8'hFC;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_PAUSE  = 8'hE1;

  localparam int CODE_W     = 8;
  localparam int EV_W       = 10;
  localparam int EV_BRK_BIT = 8;
  localparam int EV_EXT_BIT = 9;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_BAT) || (b == IGN_ACK) || (b == IGN_ECHO) ||
           (b == IGN_BATF) || (b == IGN_RESEND) || (b == IGN_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 clock filter, falling-edge detect and 11-bit frame receiver with
// parity/stop checking and a mid-frame inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2d_i,
  input  logic              ps2c_i,
  output logic [CODE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              err_tick_o
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [FILT_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                filt_q, filt_d;
  logic                fall_edge;
  rx_state_e           state_q, state_d;
  logic [9:0]          sh_q, sh_d;
  logic [3:0]          nbit_q, nbit_d;
  logic [TO_W-1:0]     to_q, to_d;

  // Filtered clock only moves once the whole sample window agrees.
  always_comb begin
    filt_sr_d = {ps2c_i, filt_sr_q[FILT_LEN-1:1]};
    filt_d    = filt_q;
    if (&filt_sr_q)
      filt_d = 1'b1;
    else if (~|filt_sr_q)
      filt_d = 1'b0;
  end

  assign fall_edge = filt_q & ~filt_d;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    nbit_d       = nbit_q;
    to_d         = to_q;
    byte_valid_o = 1'b0;
    err_tick_o   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_edge) begin
          if (!ps2d_i) begin
            state_d = RX_SHIFT;
            nbit_d  = 4'd0;
            to_d    = '0;
          end else begin
            err_tick_o = 1'b1;
          end
        end
      end
      RX_SHIFT: begin
        // Eight data bits, parity, then stop, all shifted in LSB first.
        if (fall_edge) begin
          sh_d = {ps2d_i, sh_q[9:1]};
          to_d = '0;
          if (nbit_q == 4'd9)
            state_d = RX_CHECK;
          else
            nbit_d = nbit_q + 4'd1;
        end else if (to_q == TO_LAST) begin
          state_d    = RX_IDLE;
          err_tick_o = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      RX_CHECK: begin
        if ((^sh_q[8:0]) && sh_q[9])
          byte_valid_o = 1'b1;
        else
          err_tick_o = 1'b1;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = sh_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_sr_q <= '0;
      filt_q    <= 1'b0;
      state_q   <= RX_IDLE;
      nbit_q    <= 4'd0;
      to_q      <= '0;
    end else begin
      filt_sr_q <= filt_sr_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      nbit_q    <= nbit_d;
      to_q      <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: rtl/ps2_kb_event.sv
// PS/2 keyboard to tagged key-event FIFO (FWFT). Define PS2_MAKE_EVENT_EN to
// also queue make (press) events; by default only releases are queued.
module ps2_kb_event
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2d,
  input  logic              ps2c,
  input  logic              rd,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_ext,
  output logic              ev_brk,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              frame_err,
  input  logic              err_clr
);

`ifdef PS2_MAKE_EVENT_EN
  localparam logic MAKE_EN = 1'b1;
`else
  localparam logic MAKE_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  logic [CODE_W-1:0] rx_byte;
  logic              rx_valid;
  logic              err_tick;

  ps2_frame_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .rst_n       (reset),
    .ps2d_i      (ps2d),
    .ps2c_i      (ps2c),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .err_tick_o  (err_tick)
  );

  dec_state_e      dec_q, dec_d;
  logic            push;
  logic [EV_W-1:0] push_ev;

  // Prefix decoder: status bytes abandon any pending prefix.
  always_comb begin
    dec_d   = dec_q;
    push    = 1'b0;
    push_ev = {2'b00, rx_byte};
    if (rx_valid) begin
      if (is_ignored(rx_byte)) begin
        dec_d = DEC_BASE;
      end else begin
        case (dec_q)
          DEC_BASE: begin
            if (rx_byte == EXT)
              dec_d = DEC_EXT;
            else if (rx_byte == BRK)
              dec_d = DEC_BRK;
            else
              push = MAKE_EN;
          end
          DEC_EXT: begin
            if (rx_byte == BRK) begin
              dec_d = DEC_EXT_BRK;
            end else begin
              push                = MAKE_EN;
              push_ev[EV_EXT_BIT] = 1'b1;
              dec_d               = DEC_BASE;
            end
          end
          DEC_BRK: begin
            push                = 1'b1;
            push_ev[EV_BRK_BIT] = 1'b1;
            dec_d               = DEC_BASE;
          end
          DEC_EXT_BRK: begin
            push                = 1'b1;
            push_ev[EV_EXT_BIT] = 1'b1;
            push_ev[EV_BRK_BIT] = 1'b1;
            dec_d               = DEC_BASE;
          end
          default: dec_d = DEC_BASE;
        endcase
      end
    end
  end

  logic [EV_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [EV_W-1:0] head_q, head_d, head;
  logic            do_rd, do_wr;
  logic            ovf_q, ovf_d, ferr_q, ferr_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                 (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign do_rd = rd & ~empty;
  assign do_wr = push & (~full | do_rd);

  // head_q remembers the last visible entry so outputs hold once drained.
  assign head   = empty ? head_q : mem[rd_q[FIFO_AW-1:0]];
  assign head_d = head;
  assign wr_d   = wr_q + PW'(do_wr);
  assign rd_d   = rd_q + PW'(do_rd);

  assign ev_code = head[CODE_W-1:0];
  assign ev_brk  = head[EV_BRK_BIT];
  assign ev_ext  = head[EV_EXT_BIT];

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (err_clr) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (push && full && !do_rd)
      ovf_d = 1'b1;
    if (err_tick)
      ferr_d = 1'b1;
  end

  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q  <= DEC_BASE;
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      dec_q  <= dec_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_q[FIFO_AW-1:0]] <= push_ev;
  end

endmodule

// File: tb/tb_ps2_kb_event.sv
// Self-checking bench for ps2_kb_event: PS/2 frames driven bit by bit, key events
// predicted by a prefix-flag model of scan set 2 and a bounded event queue.
module tb_ps2_kb_event;

  localparam int FILT_LEN    = 8;
  localparam int FIFO_AW     = 3;
  localparam int TIMEOUT_CYC = 600;
  localparam int DEPTH       = 1 << FIFO_AW;

`ifdef PS2_MAKE_EVENT_EN
  localparam logic MAKE_EN = 1'b1;
`else
  localparam logic MAKE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, ps2d, ps2c, rd, err_clr;
  logic [7:0] ev_code;
  logic       ev_ext, ev_brk, empty, full, overflow, frame_err;

  int total = 0;
  int bad   = 0;

  logic [9:0] mq[$];
  logic       m_ext, m_brk, exp_ovf;
  logic [9:0] last_ev;
  bit         glitch_en;

  always #5 clk = ~clk;

  ps2_kb_event #(
    .FILT_LEN   (FILT_LEN),
    .FIFO_AW    (FIFO_AW),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2d     (ps2d),
    .ps2c     (ps2c),
    .rd       (rd),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .frame_err(frame_err),
    .err_clr  (err_clr)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Reference: E0/F0 are remembered as flags; the next ordinary byte forms the event.
  function automatic void model_reset();
    mq.delete();
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    exp_ovf = 1'b0;
    last_ev = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'hE1}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1'b1;
    end else begin
      if (m_brk || MAKE_EN) begin
        if (mq.size() == DEPTH) exp_ovf = 1'b1;
        else mq.push_back({m_ext, m_brk, b});
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (3) @(negedge clk);
    if (glitch_en && $urandom_range(3) == 0) begin
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
    end else begin
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    ps2c = 1'b0;
    repeat (12) @(negedge clk);
    ps2c = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Stop bit is driven inline so empty can be sampled on exact cycles around the push.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit clr_on_push, output bit e9, output bit e10);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    ps2d = ~bad_stop;
    repeat (6) @(negedge clk);
    ps2c = 1'b0;
    repeat (9) @(posedge clk);
    #1 e9 = empty;
    if (clr_on_push) err_clr = 1'b1;
    @(posedge clk);
    #1 e10 = empty;
    err_clr = 1'b0;
    repeat (10) @(negedge clk);
    ps2c = 1'b1;
    repeat (12) @(negedge clk);
    if (!bad_par && !bad_stop) model_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    bit a, c;
    send_frame(b, 1'b0, 1'b0, 1'b0, a, c);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] exp;
    @(negedge clk);
    exp = mq.pop_front();
    total++;
    if (empty !== 1'b0 || {ev_ext, ev_brk, ev_code} !== exp) begin
      bad++;
      $display("FAIL %s: got empty=%b ext/brk/code=%h, want empty=0 ext/brk/code=%h",
               tag, empty, {ev_ext, ev_brk, ev_code}, exp);
    end
    last_ev = exp;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_check(tag);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || {ev_ext, ev_brk, ev_code} !== last_ev) begin
      bad++;
      $display("FAIL %s_drained: got empty=%b full=%b head=%h, want empty=1 full=0 head=%h",
               tag, empty, full, {ev_ext, ev_brk, ev_code}, last_ev);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2d = 1'b1; ps2c = 1'b1; rd = 1'b0; err_clr = 1'b0; glitch_en = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    total++;
    if ({empty, full, overflow, frame_err, ev_ext, ev_brk, ev_code} !== 14'b10_0000_0000_0000) begin
      bad++;
      $display("FAIL reset_async: got e/f/o/fe/x/b/code=%b, want 10000000000000",
               {empty, full, overflow, frame_err, ev_ext, ev_brk, ev_code});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if ({empty, full, overflow, frame_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_idle: got e/f/o/fe=%b, want 1000", {empty, full, overflow, frame_err});
    end
  endtask

  task automatic test_break_single();
    bit e9, e10;
    send(8'h1C);
    drain("make_1c");
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, e9, e10);
    total++;
    if (e9 !== 1'b1 || e10 !== 1'b0) begin
      bad++;
      $display("FAIL push_latency: got empty %b then %b, want 1 then 0", e9, e10);
    end
    drain("brk_1c");
  endtask

  task automatic test_ext_make_break();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext_75");
  endtask

  task automatic test_frame_errors();
    bit a, c;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, a, c);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1 || empty !== 1'b1) begin
      bad++;
      $display("FAIL parity_err: got frame_err=%b empty=%b, want 1 1", frame_err, empty);
    end
    send(8'hF0); send(8'h1C);
    drain("after_parity");
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got frame_err=%b, want 1", frame_err);
    end
    pulse_clr();
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got frame_err=%b, want 0", frame_err);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, a, c);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1 || empty !== 1'b1) begin
      bad++;
      $display("FAIL stop_err: got frame_err=%b empty=%b, want 1 1", frame_err, empty);
    end
    pulse_clr();
    send_bit(1'b1);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL bad_start: got frame_err=%b, want 1", frame_err);
    end
    pulse_clr();
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr2: got frame_err=%b, want 0", frame_err);
    end
  endtask

  task automatic test_timeout();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TIMEOUT_CYC / 2) @(negedge clk);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got frame_err=%b, want 0", frame_err);
    end
    repeat (TIMEOUT_CYC) @(negedge clk);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout: got frame_err=%b, want 1", frame_err);
    end
    send(8'hF0); send(8'h23);
    drain("after_timeout");
    pulse_clr();
  endtask

  task automatic test_fifo_full();
    bit a, c;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'hF0);
      send(8'h10 + 8'(i));
      if (i == DEPTH - 2) begin
        total++;
        if (full !== 1'b0) begin
          bad++;
          $display("FAIL not_full: got full=%b, want 0", full);
        end
      end
    end
    total++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full: got full=%b overflow=%b, want 1 0", full, overflow);
    end
    send(8'hF0);
    send_frame(8'h10 + 8'(DEPTH), 1'b0, 1'b0, 1'b1, a, c);
    total++;
    if (overflow !== exp_ovf || full !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got overflow=%b full=%b, want %b 1", overflow, full, exp_ovf);
    end
    pop_check("fifo_order");
    @(negedge clk);
    total++;
    if (full !== 1'b0) begin
      bad++;
      $display("FAIL full_after_pop: got full=%b, want 0", full);
    end
    drain("fifo_order");
    pulse_clr();
    exp_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: got overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_reset_midframe();
    send(8'hE0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    total++;
    if ({empty, overflow, frame_err, ev_ext, ev_brk, ev_code} !== 13'b1_0000_0000_0000) begin
      bad++;
      $display("FAIL reset_mid: got e/o/fe/x/b/code=%b, want 1000000000000",
               {empty, overflow, frame_err, ev_ext, ev_brk, ev_code});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send(8'hF0); send(8'h29);
    drain("after_reset");
    total++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL flags_after_reset: got overflow=%b frame_err=%b, want 0 0", overflow, frame_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] code;
    bit ext;
    glitch_en = 1;
    for (int k = 0; k < 20; k++) begin
      code = 8'($urandom_range(8'h7F, 8'h01));
      ext  = $urandom_range(1);
      if (ext) send(8'hE0);
      if ($urandom_range(7) == 0) send(($urandom_range(1) != 0) ? 8'hAA : 8'hFA);
      send(code);
      if (ext) send(8'hE0);
      send(8'hF0);
      send(code);
      if (mq.size() >= 5 || $urandom_range(2) == 0) drain("random");
    end
    drain("random");
    glitch_en = 0;
    total++;
    if (overflow !== exp_ovf || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL random_flags: got overflow=%b frame_err=%b, want %b 0", overflow, frame_err, exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_break_single();
    test_ext_make_break();
    test_frame_errors();
    test_timeout();
    test_fifo_full();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kb_event.md
Name: ps2_kb_event

Overview:
- Parametrised successor to the PS/2 keyboard receive path: clk-domain filtering of ps2c, 11-bit frame reception with parity/stop checking and inactivity timeout.
- Scan-set-2 decoding of E0 (extended) and F0 (break) prefixes into tagged key events, buffered in a first-word-fall-through event FIFO.
- Sits between the PS/2 pins and the key-to-data lookup and display logic; consumers pop one event per rd pulse.

Parameters:
- FILT_LEN, 8: ps2c filter length in clk cycles; all-ones or all-zeros window changes the filtered clock.
- FIFO_AW, 3: event FIFO address width; depth = 2**FIFO_AW.
- TIMEOUT_CYC, 50000: clk cycles without a filtered falling edge mid-frame before the frame is abandoned; counter width = $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ps2d  in  1  PS/2 data pin, raw
- ps2c  in  1  PS/2 clock pin, raw
- rd  in  1  pop head event; ignored when empty
- ev_code  out  8  head event scan code (final byte, prefixes stripped)
- ev_ext  out  1  head event had E0 prefix
- ev_brk  out  1  head event is a release (F0 seen)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- overflow  out  1  sticky: event dropped because FIFO full
- frame_err  out  1  sticky: parity, stop-bit or timeout error seen
- err_clr  in  1  single-cycle clear of overflow and frame_err

Behaviour:
- Reset (reset=0, asynchronous): FSMs idle/base, FIFO pointers 0, filter regs 0, filtered clock 0.
  Outputs: empty=1, full=0, overflow=0, frame_err=0, ev_code=0, ev_ext=0, ev_brk=0.
  Reset mid-frame discards partial frame and prefix state.
- Filter: shift register of FILT_LEN samples; fall_edge = filtered 1->0 transition, one clk wide.
- Frame FSM:
  - idle -> shift on fall_edge when ps2d=0 (start bit). A fall_edge with ps2d=1 stays idle and sets frame_err.
  - shift: 8 data bits LSB first, then parity, then stop; then check.
  - check (1 cycle): byte_valid when odd parity holds (data^parity == 1) and stop==1; otherwise frame_err set, byte dropped; return to idle.
  - Timeout: in shift, TIMEOUT_CYC clk cycles with no fall_edge -> idle, frame_err set. The counter reloads on every fall_edge.
- Decoder FSM (states base, ext, brk, ext_brk), advanced only on byte_valid:
  - base: E0 -> ext; F0 -> brk; other -> push event.
  - ext: F0 -> ext_brk; other -> push ext=1 event, -> base.
  - brk: any -> push brk=1 event, -> base.
  - ext_brk: any -> push ext=1, brk=1 event, -> base.
  - Bytes AA, FA, EE, FC, FE, E1 in any state: no push, return to base.
  - Make events (brk=0) are pushed only under PS2_MAKE_EVENT_EN (see Optional Feature); otherwise they are silently consumed.
- Push latency: event visible at FIFO head (empty falls) 1 clk after the check cycle.
- FIFO:
  - 10-bit entries {ext, brk, code}; FWFT outputs reflect mem[rd_ptr] whenever empty=0.
  - Pointers are FIFO_AW+1 bits; full/empty derive from MSB compare, so wrap-around is exact.
  - Simultaneous push and rd when full: both succeed, full stays 1.
  - Simultaneous push and rd when empty: push succeeds, rd ignored.
  - Push when full without rd: entry dropped, overflow set.
  - Outputs hold the last head value when empty.
- err_clr in the same cycle as a new error: the error wins (stays set).

Optional Feature:
- PS2_MAKE_EVENT_EN defined: make codes also pushed (brk=0), so each keystroke yields press and release events.
- Undefined: only break events pushed, i.e. one event per keystroke on release (legacy behaviour).

Decomposition:
- Package ps2_pkg:
  - localparams BRK=8'hF0, EXT=8'hE0, and the filtered-code set AA/FA/EE/FC/FE/E1.
  - event field widths and bit offsets (EV_W=10).
  - decoder state encodings.
- Sub-module ps2_frame_rx: filter, fall-edge detect, frame FSM, timeout. Outputs byte, byte_valid, err_tick.
- FIFO and decoder live in the top module.

Test Plan:
- Frame 1C, then F0 1C, macro undefined -> exactly one event {code=1C, ext=0, brk=1}, empty falls 1 clk after the final check cycle.
- E0 F0 75 (Up release) with PS2_MAKE_EVENT_EN defined, preceded by E0 75 -> two events: {75,1,0} then {75,1,1}.
- Byte 1C sent with even parity -> frame_err=1, no event, next valid F0 1C decodes correctly; err_clr pulse -> frame_err=0.
- Stop sending clocks after 4 data bits for TIMEOUT_CYC+1 cycles -> frame_err=1, FSM idle, following full frame F0 23 yields {23,0,1}.
- FIFO_AW=3: 9 release events with no rd -> full=1 after 8, overflow=1, the 9th dropped; 8 rd pulses return codes in order, empty=1 after the 8th.
- Assert reset=0 mid-frame after E0 received, release, send F0 29 -> event {29,0,1} (ext prefix cleared), all sticky flags 0.
